pipelined_cpu: RTL and testbench
================================

// Module: pipelined_cpu
// PURPOSE
//  5-stage in-order MIPS-subset CPU (IF/ID/EX/MEM/WB). Top of the processor
//  hierarchy. Owns the instruction memory, data memory and register file.
//  Has load-use hazard detection, EX-stage forwarding, and branch/jump
//  resolution in ID with a one-slot flush.
// PARAMETERS
//  IMEM_WORDS  256  instruction memory depth, 32-bit words
//  DMEM_BYTES  32   data memory size in bytes
// PORTS
//  clk_i    in   1  clock; all state updates on rising edge
//  start_i  in   1  asynchronous, active-low reset; 1 = run
//  stall_o  out  1  high in a cycle where a load-use bubble is inserted
//  flush_o  out  1  high in a cycle where a taken beq/j flushes IF/ID
// BEHAVIOUR
//  Backdoor instance/array names, kept exactly for bench preload/inspection:
//   Instruction_Memory.memory[IMEM_WORDS] x32, PC.pc_o (32b),
//   Registers.register[32] x32, Data_Memory.memory[DMEM_BYTES] x8.
//   Words in data memory are little-endian: byte 0 is the LSB.
//  Reset (start_i=0):
//   - PC=0; all pipeline registers cleared to NOP (all control bits 0).
//   - stall_o=0, flush_o=0.
//   - Memories and register file are NOT cleared by reset.
//  ISA (32-bit MIPS encodings):
//   - R-type op 000000: add(f=100000), sub(100010), and(100100),
//     or(100101), mul(011000, low 32 bits of product).
//   - I-type: addi(001000, sign-extended imm), lw(100011), sw(101011),
//     beq(000100).
//   - J-type: j(000010).
//   - All other encodings, incl. 0x00000000, execute as NOP (no state change).
//  Pipeline:
//   - IF: fetch imem[PC>>2]; PC+=4 per cycle.
//   - ID: decode, read regs, resolve beq/j.
//   - EX: ALU. MEM: dmem word read/write at ALU address.
//   - WB: result written to rd (R-type) or rt (addi/lw).
//   - Result is architecturally visible at the end of its 5th cycle.
//  Register file:
//   - r0 reads 0; writes to r0 ignored.
//   - Write-before-read: an ID read of a reg being written in WB the same
//     cycle returns the new value.
//  Forwarding (EX operands, rs and rt):
//   - Priority: EX/MEM result, then MEM/WB result, then ID/EX value.
//   - Applies only if source RegWrite=1 and dest != 0.
//   - sw store data uses the forwarded rt.
//  Load-use hazard:
//   - Trigger: ID/EX is lw with rt == ID rs or ID rt.
//   - PC and IF/ID hold one cycle; ID/EX gets a bubble; stall_o=1 that cycle.
//  Branch/jump (resolved in ID):
//   - beq target = PC+4 + (sext(imm)<<2).
//   - j target = {PC+4[31:28], addr26, 2'b00}.
//   - beq compares raw register-file outputs; no forwarding into ID.
//     Software separates dependent producers by >=2 instructions.
//   - When taken: PC <- target; IF/ID loaded with NOP; flush_o=1.
//     Penalty is one cycle.
//  Simultaneous events:
//   - Load-use stall overrides branch: branch waits in ID, flush_o=0 that
//     cycle, and it resolves the next cycle.
//  Boundaries:
//   - PC wraps modulo IMEM_WORDS*4.
//   - Data address uses addr[4:2] word index; unaligned low bits ignored.
//   - Arithmetic wraps mod 2^32; no overflow traps.
//  Reset mid-operation: immediate return to reset state; memory contents kept.
// TESTING
//  1. addi r8,r0,5; addi r9,r0,3; add r10,r8,r9 (back-to-back)
//     -> r10=8 via forwarding; stall_o never 1.
//  2. dmem[0]=5; lw r8,0(r0); add r9,r8,r8
//     -> one cycle stall_o=1, r9=10; total 1 stall.
//  3. addi r8,r0,7; 2 NOPs; beq r8,r8,+2
//     -> flush_o=1 once; skipped instr never writes; PC lands at target.
//  4. j 0x10 at PC 0 -> next fetched PC 0x10; flush_o count 1.
//  5. addi r8,r0,-3; sw r8,4(r0); mul r9,r8,r8
//     -> dmem bytes 4..7 = FD FF FF FF; r9=9.
//  6. start_i low mid-run -> PC=0, pipeline empty; regs/dmem keep values.

Source files
------------

// File: rtl/pipelined_cpu.sv
// 5-stage in-order MIPS-subset CPU (IF/ID/EX/MEM/WB) with EX-stage forwarding,
// load-use stall and beq/j resolution in ID with a one-slot flush.

module pipelined_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic clk_i,
  input  logic start_i,
  output logic stall_o,
  output logic flush_o
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DBW = $clog2(DMEM_BYTES);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_MUL = 6'b011000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // IF
  logic [31:0] pc_q, pc_d, pc_plus4, fetch_instr;
  logic [31:0] if_id_instr_q, if_id_instr_d, if_id_pc4_q, if_id_pc4_d;

  // ID
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, id_rs_val, id_rt_val, branch_target;
  ctrl_t       id_ctrl;
  logic [4:0]  id_dest;
  logic        is_beq, is_j, branch_taken, load_use, flush;

  // ID/EX
  ctrl_t       id_ex_ctrl_q, id_ex_ctrl_d;
  logic [31:0] id_ex_rs_val_q, id_ex_rs_val_d, id_ex_rt_val_q, id_ex_rt_val_d;
  logic [31:0] id_ex_imm_q, id_ex_imm_d;
  logic [4:0]  id_ex_rs_q, id_ex_rs_d, id_ex_rt_q, id_ex_rt_d, id_ex_dest_q, id_ex_dest_d;

  // EX
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result;

  // EX/MEM
  logic        ex_mem_reg_write_q, ex_mem_mem_read_q, ex_mem_mem_write_q;
  logic [4:0]  ex_mem_dest_q;
  logic [31:0] ex_mem_alu_q, ex_mem_store_q, dmem_rdata;

  // MEM/WB
  logic        mem_wb_reg_write_q, mem_wb_reg_write_d;
  logic [4:0]  mem_wb_dest_q;
  logic [31:0] mem_wb_value_q, mem_wb_value_d;

  pc_reg PC (
    .clk_i (clk_i),
    .rst_n (start_i),
    .en_i  (!load_use),
    .pc_i  (pc_d),
    .pc_o  (pc_q)
  );

  instruction_memory #(.WORDS(IMEM_WORDS)) Instruction_Memory (
    .index_i (pc_q[IAW+1:2]),
    .instr_o (fetch_instr)
  );

  register_file Registers (
    .clk_i    (clk_i),
    .we_i     (mem_wb_reg_write_q),
    .waddr_i  (mem_wb_dest_q),
    .wdata_i  (mem_wb_value_q),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (id_rs_val),
    .rdata2_o (id_rt_val)
  );

  data_memory #(.BYTES(DMEM_BYTES)) Data_Memory (
    .clk_i   (clk_i),
    .we_i    (ex_mem_mem_write_q),
    .index_i (ex_mem_alu_q[DBW-1:2]),
    .wdata_i (ex_mem_store_q),
    .rdata_o (dmem_rdata)
  );

  assign op      = if_id_instr_q[31:26];
  assign rs      = if_id_instr_q[25:21];
  assign rt      = if_id_instr_q[20:16];
  assign rd      = if_id_instr_q[15:11];
  assign funct   = if_id_instr_q[5:0];
  assign imm_ext = {{16{if_id_instr_q[15]}}, if_id_instr_q[15:0]};

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_ctrl = '0;
    id_dest = '0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (op)
      OP_RTYPE: begin
        id_dest = rd;
        case (funct)
          F_ADD:   id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD};
          F_SUB:   id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_SUB};
          F_AND:   id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_AND};
          F_OR:    id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_OR};
          F_MUL:   id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_MUL};
          default: id_dest = '0;
        endcase
      end
      OP_ADDI: begin
        id_ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b1, alu_op: ALU_ADD};
        id_dest = rt;
      end
      OP_LW: begin
        id_ctrl = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, alu_src: 1'b1, alu_op: ALU_ADD};
        id_dest = rt;
      end
      OP_SW:   id_ctrl = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD};
      OP_BEQ:  is_beq = 1'b1;
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // beq compares raw register-file values; software spaces dependent producers.
  assign branch_taken  = (is_beq && (id_rs_val == id_rt_val)) || is_j;
  assign branch_target = is_j ? {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00}
                              : (if_id_pc4_q + {imm_ext[29:0], 2'b00});
  assign load_use      = id_ex_ctrl_q.mem_read && ((id_ex_dest_q == rs) || (id_ex_dest_q == rt));
  assign flush         = branch_taken && !load_use;
  assign pc_plus4      = (pc_q + 32'd4) & PC_MASK;

  always_comb begin
    pc_d          = pc_plus4;
    if_id_instr_d = fetch_instr;
    if_id_pc4_d   = pc_plus4;
    id_ex_ctrl_d   = id_ctrl;
    id_ex_rs_val_d = id_rs_val;
    id_ex_rt_val_d = id_rt_val;
    id_ex_imm_d    = imm_ext;
    id_ex_rs_d     = rs;
    id_ex_rt_d     = rt;
    id_ex_dest_d   = id_dest;
    if (load_use) begin
      // PC is held by its enable; IF/ID holds and ID/EX takes a bubble.
      if_id_instr_d  = if_id_instr_q;
      if_id_pc4_d    = if_id_pc4_q;
      id_ex_ctrl_d   = '0;
      id_ex_rs_val_d = '0;
      id_ex_rt_val_d = '0;
      id_ex_imm_d    = '0;
      id_ex_rs_d     = '0;
      id_ex_rt_d     = '0;
      id_ex_dest_d   = '0;
    end else if (flush) begin
      pc_d          = branch_target & PC_MASK;
      if_id_instr_d = '0;
      if_id_pc4_d   = '0;
    end
  end

  // NOTE: blocking assignments are correct here: later ifs override earlier ones, which encodes forwarding priority.
  always_comb begin
    fwd_a = id_ex_rs_val_q;
    fwd_b = id_ex_rt_val_q;
    if (mem_wb_reg_write_q && (mem_wb_dest_q != 5'd0) && (mem_wb_dest_q == id_ex_rs_q)) fwd_a = mem_wb_value_q;
    if (mem_wb_reg_write_q && (mem_wb_dest_q != 5'd0) && (mem_wb_dest_q == id_ex_rt_q)) fwd_b = mem_wb_value_q;
    if (ex_mem_reg_write_q && (ex_mem_dest_q != 5'd0) && (ex_mem_dest_q == id_ex_rs_q)) fwd_a = ex_mem_alu_q;
    if (ex_mem_reg_write_q && (ex_mem_dest_q != 5'd0) && (ex_mem_dest_q == id_ex_rt_q)) fwd_b = ex_mem_alu_q;
  end

  assign alu_b = id_ex_ctrl_q.alu_src ? id_ex_imm_q : fwd_b;

  always_comb begin
    case (id_ex_ctrl_q.alu_op)
      ALU_ADD: alu_result = fwd_a + alu_b;
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_MUL: alu_result = fwd_a * alu_b;
      default: alu_result = '0;
    endcase
  end

  assign mem_wb_reg_write_d = ex_mem_reg_write_q;
  assign mem_wb_value_d     = ex_mem_mem_read_q ? dmem_rdata : ex_mem_alu_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous cycle's values.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      if_id_instr_q      <= '0;
      if_id_pc4_q        <= '0;
      id_ex_ctrl_q       <= '0;
      id_ex_rs_val_q     <= '0;
      id_ex_rt_val_q     <= '0;
      id_ex_imm_q        <= '0;
      id_ex_rs_q         <= '0;
      id_ex_rt_q         <= '0;
      id_ex_dest_q       <= '0;
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_mem_read_q  <= 1'b0;
      ex_mem_mem_write_q <= 1'b0;
      ex_mem_dest_q      <= '0;
      ex_mem_alu_q       <= '0;
      ex_mem_store_q     <= '0;
      mem_wb_reg_write_q <= 1'b0;
      mem_wb_dest_q      <= '0;
      mem_wb_value_q     <= '0;
    end else begin
      if_id_instr_q      <= if_id_instr_d;
      if_id_pc4_q        <= if_id_pc4_d;
      id_ex_ctrl_q       <= id_ex_ctrl_d;
      id_ex_rs_val_q     <= id_ex_rs_val_d;
      id_ex_rt_val_q     <= id_ex_rt_val_d;
      id_ex_imm_q        <= id_ex_imm_d;
      id_ex_rs_q         <= id_ex_rs_d;
      id_ex_rt_q         <= id_ex_rt_d;
      id_ex_dest_q       <= id_ex_dest_d;
      ex_mem_reg_write_q <= id_ex_ctrl_q.reg_write;
      ex_mem_mem_read_q  <= id_ex_ctrl_q.mem_read;
      ex_mem_mem_write_q <= id_ex_ctrl_q.mem_write;
      ex_mem_dest_q      <= id_ex_dest_q;
      ex_mem_alu_q       <= alu_result;
      ex_mem_store_q     <= fwd_b;
      mem_wb_reg_write_q <= mem_wb_reg_write_d;
      mem_wb_dest_q      <= ex_mem_dest_q;
      mem_wb_value_q     <= mem_wb_value_d;
    end
  end

  assign stall_o = load_use;
  assign flush_o = flush;

endmodule

module pc_reg (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)    pc_o <= '0;
    else if (en_i) pc_o <= pc_i;
  end
endmodule

module instruction_memory #(
  parameter int WORDS = 256
) (
  input  logic [$clog2(WORDS)-1:0] index_i,
  output logic [31:0]              instr_o
);
  logic [31:0] memory [WORDS];

  assign instr_o = memory[index_i];
endmodule

module register_file (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] register [32];

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    rdata1_o = register[raddr1_i];
    rdata2_o = register[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = '0;
    if (raddr2_i == 5'd0) rdata2_o = '0;
  end

  // NOTE: storage arrays have no reset branch; their contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) register[waddr_i] <= wdata_i;
  end
endmodule

module data_memory #(
  parameter int BYTES = 32
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(BYTES)-3:0]   index_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);
  logic [7:0] memory [BYTES];

  // Little-endian words: byte 0 of each word is the LSB.
  assign rdata_o = {memory[{index_i, 2'd3}], memory[{index_i, 2'd2}],
                    memory[{index_i, 2'd1}], memory[{index_i, 2'd0}]};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[{index_i, 2'd0}] <= wdata_i[7:0];
      memory[{index_i, 2'd1}] <= wdata_i[15:8];
      memory[{index_i, 2'd2}] <= wdata_i[23:16];
      memory[{index_i, 2'd3}] <= wdata_i[31:24];
    end
  end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed self-checking bench for pipelined_cpu: forwarding, load-use stall,
// beq/j flush, sw/mul data path and mid-run reset with state retention.

module tb_pipelined_cpu;
  logic clk_i   = 1'b0;
  logic start_i = 1'b1;
  logic stall_o, flush_o;

  int errors = 0;
  int checks = 0;
  int stall_cnt, flush_cnt;
  logic [31:0] pc_after_flush;

  pipelined_cpu dut (
    .clk_i   (clk_i),
    .start_i (start_i),
    .stall_o (stall_o),
    .flush_o (flush_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] MUL  = 6'b011000;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] addr);
    return {6'b000010, addr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Assert reset, then blank the program memory so unused slots are NOPs.
  task automatic enter_reset();
    start_i = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
  endtask

  task automatic leave_reset();
    @(negedge clk_i);
    start_i   = 1'b1;
    stall_cnt = 0;
    flush_cnt = 0;
    pc_after_flush = 32'hDEAD_BEEF;
  endtask

  task automatic run(input int n);
    logic pend;
    pend = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (pend) begin
        pc_after_flush = dut.PC.pc_o;
        pend = 1'b0;
      end
      if (stall_o) stall_cnt++;
      if (flush_o) begin
        flush_cnt++;
        pend = 1'b1;
      end
    end
  endtask

  initial begin
    #2;
    enter_reset();
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_flush", {31'd0, flush_o}, 32'd0);

    // 1: back-to-back dependence resolved by forwarding
    dut.Instruction_Memory.memory[0] = enc_i(ADDI, 5'd0, 5'd8, 16'd5);
    dut.Instruction_Memory.memory[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd3);
    dut.Instruction_Memory.memory[2] = enc_r(5'd8, 5'd9, 5'd10, ADD);
    dut.Instruction_Memory.memory[3] = enc_i(ADDI, 5'd0, 5'd14, 16'd0);
    leave_reset();
    run(12);
    check("t1_r8", dut.Registers.register[8], 32'd5);
    check("t1_r9", dut.Registers.register[9], 32'd3);
    check("t1_r10_fwd", dut.Registers.register[10], 32'd8);
    check("t1_stalls", stall_cnt, 32'd0);

    // 2: load-use inserts exactly one bubble
    enter_reset();
    dut.Instruction_Memory.memory[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd5);
    dut.Instruction_Memory.memory[1] = enc_i(SW, 5'd0, 5'd1, 16'd0);
    dut.Instruction_Memory.memory[2] = enc_i(LW, 5'd0, 5'd8, 16'd0);
    dut.Instruction_Memory.memory[3] = enc_r(5'd8, 5'd8, 5'd9, ADD);
    leave_reset();
    run(14);
    check("t2_dmem0", {24'd0, dut.Data_Memory.memory[0]}, 32'd5);
    check("t2_r8_lw", dut.Registers.register[8], 32'd5);
    check("t2_r9", dut.Registers.register[9], 32'd10);
    check("t2_stalls", stall_cnt, 32'd1);
    check("t2_flushes", flush_cnt, 32'd0);

    // 3: taken beq with two-NOP separation; 0x18 is flushed, 0x1C never fetched
    enter_reset();
    dut.Instruction_Memory.memory[0] = enc_i(ADDI, 5'd0, 5'd11, 16'd0);
    dut.Instruction_Memory.memory[1] = enc_i(ADDI, 5'd0, 5'd13, 16'd0);
    dut.Instruction_Memory.memory[2] = enc_i(ADDI, 5'd0, 5'd8, 16'd7);
    dut.Instruction_Memory.memory[5] = enc_i(BEQ, 5'd8, 5'd8, 16'd2);
    dut.Instruction_Memory.memory[6] = enc_i(ADDI, 5'd0, 5'd11, 16'd99);
    dut.Instruction_Memory.memory[7] = enc_i(ADDI, 5'd0, 5'd13, 16'd55);
    dut.Instruction_Memory.memory[8] = enc_i(ADDI, 5'd0, 5'd12, 16'd1);
    leave_reset();
    run(20);
    check("t3_flushes", flush_cnt, 32'd1);
    check("t3_target_pc", pc_after_flush, 32'h20);
    check("t3_r11_flushed", dut.Registers.register[11], 32'd0);
    check("t3_r13_skipped", dut.Registers.register[13], 32'd0);
    check("t3_r12_target", dut.Registers.register[12], 32'd1);
    check("t3_stalls", stall_cnt, 32'd0);

    // 4: j 0x10 from PC 0
    enter_reset();
    dut.Instruction_Memory.memory[0] = enc_j(26'd4);
    dut.Instruction_Memory.memory[1] = enc_i(ADDI, 5'd0, 5'd14, 16'd66);
    dut.Instruction_Memory.memory[4] = enc_i(ADDI, 5'd0, 5'd15, 16'd5);
    leave_reset();
    run(12);
    check("t4_flushes", flush_cnt, 32'd1);
    check("t4_next_pc", pc_after_flush, 32'h10);
    check("t4_r14_flushed", dut.Registers.register[14], 32'd0);
    check("t4_r15", dut.Registers.register[15], 32'd5);

    // 5: negative immediate, forwarded store data, mul
    enter_reset();
    dut.Instruction_Memory.memory[0] = enc_i(ADDI, 5'd0, 5'd8, 16'hFFFD);
    dut.Instruction_Memory.memory[1] = enc_i(SW, 5'd0, 5'd8, 16'd4);
    dut.Instruction_Memory.memory[2] = enc_r(5'd8, 5'd8, 5'd9, MUL);
    leave_reset();
    run(12);
    check("t5_r8", dut.Registers.register[8], 32'hFFFF_FFFD);
    check("t5_dmem4", {24'd0, dut.Data_Memory.memory[4]}, 32'hFD);
    check("t5_dmem5", {24'd0, dut.Data_Memory.memory[5]}, 32'hFF);
    check("t5_dmem6", {24'd0, dut.Data_Memory.memory[6]}, 32'hFF);
    check("t5_dmem7", {24'd0, dut.Data_Memory.memory[7]}, 32'hFF);
    check("t5_r9_mul", dut.Registers.register[9], 32'd9);

    // 6: reset while writes are still in flight; they must be dropped
    enter_reset();
    dut.Instruction_Memory.memory[0] = enc_i(ADDI, 5'd0, 5'd9, 16'd100);
    dut.Instruction_Memory.memory[1] = enc_i(ADDI, 5'd0, 5'd12, 16'd100);
    leave_reset();
    run(3);
    start_i = 1'b0;
    #1;
    check("t6_reset_pc", dut.PC.pc_o, 32'd0);
    check("t6_reset_stall", {31'd0, stall_o}, 32'd0);
    check("t6_reset_flush", {31'd0, flush_o}, 32'd0);
    enter_reset();
    leave_reset();
    run(10);
    check("t6_pc_restart", dut.PC.pc_o, 32'h28);
    check("t6_r9_kept", dut.Registers.register[9], 32'd9);
    check("t6_r12_kept", dut.Registers.register[12], 32'd1);
    check("t6_r10_kept", dut.Registers.register[10], 32'd8);
    check("t6_dmem4_kept", {24'd0, dut.Data_Memory.memory[4]}, 32'hFD);
    check("t6_dmem0_kept", {24'd0, dut.Data_Memory.memory[0]}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
